// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, opcode encoding and the fetch-queue entry layout.
// fetch_queue imports this package and takes HALT, word_t and fetch_entry_t from it.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [5:0] {
        RTYPE = 6'b000000,
        J     = 6'b000010,
        JAL   = 6'b000011,
        BEQ   = 6'b000100,
        BNE   = 6'b000101,
        ADDIU = 6'b001001,
        LW    = 6'b100011,
        SW    = 6'b101011,
        HALT  = 6'b111111
    } opcode_t;

    typedef struct packed {
        word_t instr;
        word_t pc_add4;
    } fetch_entry_t;

    localparam int FETCHQ_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one registered write port and one
// asynchronous read port. The array has no reset; validity is tracked by the parent.
module fetch_queue_mem
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = FETCHQ_DEPTH_DEFAULT
) (
    input  logic                       CLK,
    input  logic                       wen,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  fetch_entry_t               wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output fetch_entry_t               rdata
);

    fetch_entry_t mem_reg [DEPTH];

    always_ff @(posedge CLK) begin
        if (wen) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch buffer between the imem port and IF/ID: owns the fetch PC,
// queues {instr, pc+4}, handles redirect flush and HALT. Optional FETCHQ_BYPASS_EN.
module fetch_queue
    import cpu_types_pkg::*;
#(
    parameter int          DEPTH   = FETCHQ_DEPTH_DEFAULT,
    parameter logic [31:0] PC_INIT = 32'h0,
    parameter int          WORD_W  = 32
) (
    input  logic                       CLK,
    input  logic                       nRST,
    output logic                       imemREN,
    output logic [WORD_W-1:0]          imemaddr,
    input  logic                       ihit,
    input  logic [WORD_W-1:0]          imemload,
    input  logic                       deq,
    output logic                       inst_valid,
    output logic [WORD_W-1:0]          inst_out,
    output logic [WORD_W-1:0]          pc_add4_out,
    input  logic                       flush,
    input  logic [WORD_W-1:0]          redirect_pc,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       halted
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    word_t          pc_reg, pc_next;
    logic [PW-1:0]  rptr_reg, rptr_next;
    logic [PW-1:0]  wptr_reg, wptr_next;
    logic [CW-1:0]  count_reg, count_next;
    logic           halted_reg, halted_next;

    word_t          pc_add4;
    logic           q_valid;
    logic           push;
    logic           pop;
    logic           bypass;
    logic           store;
    logic           is_halt;
    fetch_entry_t   wentry;
    fetch_entry_t   head;

    assign pc_add4  = pc_reg + 32'd4;
    assign q_valid  = (count_reg != '0);
    assign imemREN  = !halted_reg && (count_reg < CW'(DEPTH));
    assign push     = ihit && imemREN && !flush;
    assign pop      = deq && q_valid;
    assign is_halt  = (opcode_t'(imemload[31:26]) == HALT);

`ifdef FETCHQ_BYPASS_EN
    // Empty queue and decode ready: hand the fetched word straight through.
    assign bypass = push && deq && !q_valid;
`else
    assign bypass = 1'b0;
`endif

    assign store         = push && !bypass;
    assign wentry.instr   = imemload;
    assign wentry.pc_add4 = pc_add4;

    fetch_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .CLK   (CLK),
        .wen   (store),
        .waddr (wptr_reg),
        .wdata (wentry),
        .raddr (rptr_reg),
        .rdata (head)
    );

    always_comb begin
        pc_next     = pc_reg;
        rptr_next   = rptr_reg;
        wptr_next   = wptr_reg;
        count_next  = count_reg;
        halted_next = halted_reg;
        if (flush) begin
            // Redirect squashes everything, including a HALT fetched on the wrong path.
            pc_next     = redirect_pc;
            rptr_next   = '0;
            wptr_next   = '0;
            count_next  = '0;
            halted_next = 1'b0;
        end else begin
            if (push) begin
                pc_next = pc_add4;
                if (is_halt) begin
                    halted_next = 1'b1;
                end
            end
            if (store) begin
                wptr_next = wptr_reg + 1'b1;
            end
            if (pop) begin
                rptr_next = rptr_reg + 1'b1;
            end
            case ({store, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_reg     <= PC_INIT;
            rptr_reg   <= '0;
            wptr_reg   <= '0;
            count_reg  <= '0;
            halted_reg <= 1'b0;
        end else begin
            pc_reg     <= pc_next;
            rptr_reg   <= rptr_next;
            wptr_reg   <= wptr_next;
            count_reg  <= count_next;
            halted_reg <= halted_next;
        end
    end

    always_comb begin
        inst_valid  = q_valid;
        inst_out    = q_valid ? head.instr : '0;
        pc_add4_out = q_valid ? head.pc_add4 : '0;
        if (bypass) begin
            inst_valid  = 1'b1;
            inst_out    = imemload;
            pc_add4_out = pc_add4;
        end
    end

    assign imemaddr = pc_reg;
    assign count    = count_reg;
    assign halted   = halted_reg;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4) plus a randomised DEPTH=2 run
// against a queue reference model.
module tb_fetch_queue;

`ifdef FETCHQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK;
    logic        nRST;

    // DEPTH=4 instance
    logic        ren4, ihit4, deq4, flush4, valid4, halted4;
    logic [31:0] addr4, load4, inst4, pa4_4, redir4;
    logic [2:0]  count4;

    // DEPTH=2 instance
    logic        ren2, ihit2, deq2, flush2, valid2, halted2;
    logic [31:0] addr2, load2, inst2, pa4_2, redir2;
    logic [1:0]  count2;

    int total;
    int passed;
    int failed;

    fetch_queue #(.DEPTH(4), .PC_INIT(32'h0), .WORD_W(32)) u4 (
        .CLK(CLK), .nRST(nRST), .imemREN(ren4), .imemaddr(addr4), .ihit(ihit4),
        .imemload(load4), .deq(deq4), .inst_valid(valid4), .inst_out(inst4),
        .pc_add4_out(pa4_4), .flush(flush4), .redirect_pc(redir4),
        .count(count4), .halted(halted4)
    );

    fetch_queue #(.DEPTH(2), .PC_INIT(32'h0), .WORD_W(32)) u2 (
        .CLK(CLK), .nRST(nRST), .imemREN(ren2), .imemaddr(addr2), .ihit(ihit2),
        .imemload(load2), .deq(deq2), .inst_valid(valid2), .inst_out(inst2),
        .pc_add4_out(pa4_2), .flush(flush2), .redirect_pc(redir2),
        .count(count2), .halted(halted2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] imem(input logic [31:0] pc);
        return 32'h2000_0000 | pc;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [31:0] q_instr[$];
    logic [31:0] q_pa4[$];
    logic [31:0] mpc;
    logic [31:0] halt_seq[3];

    initial begin
        total = 0; passed = 0; failed = 0;
        nRST = 1'b0;
        ihit4 = 0; deq4 = 0; flush4 = 0; load4 = 0; redir4 = 0;
        ihit2 = 0; deq2 = 0; flush2 = 0; load2 = 0; redir2 = 0;
        halt_seq[0] = imem(32'h0);
        halt_seq[1] = imem(32'h4);
        halt_seq[2] = 32'hFFFF_FFFF;

        #2;
        chk("rst_ren", 32'(ren4), 32'd1);
        chk("rst_valid", 32'(valid4), 32'd0);
        chk("rst_inst", inst4, 32'd0);
        chk("rst_pa4", pa4_4, 32'd0);
        chk("rst_count", 32'(count4), 32'd0);
        chk("rst_halted", 32'(halted4), 32'd0);
        chk("rst_addr", addr4, 32'd0);
        $display("txn reset: ren=%0d count=%0d addr=%h", ren4, count4, addr4);

        @(negedge CLK);
        nRST = 1'b1;

        // Fill the queue with no decode activity.
        for (int i = 0; i < 4; i++) begin
            ihit4 = 1'b1;
            load4 = imem(32'(4 * i));
            #1;
            chk("fill_addr", addr4, 32'(4 * i));
            chk("fill_count", 32'(count4), 32'(i));
            $display("txn fill: addr=%h count=%0d", addr4, count4);
            @(negedge CLK);
        end
        load4 = 32'hBAD0_0000;
        #1;
        chk("full_count", 32'(count4), 32'd4);
        chk("full_ren", 32'(ren4), 32'd0);
        chk("full_valid", 32'(valid4), 32'd1);
        chk("full_inst", inst4, imem(32'h0));
        chk("full_pa4", pa4_4, 32'd4);

        // One pop frees a slot; refill happens the cycle after.
        deq4 = 1'b1;
        @(negedge CLK);
        deq4 = 1'b0;
        load4 = imem(32'd16);
        #1;
        chk("pop1_count", 32'(count4), 32'd3);
        chk("pop1_ren", 32'(ren4), 32'd1);
        chk("pop1_addr", addr4, 32'd16);
        chk("pop1_inst", inst4, imem(32'd4));
        chk("pop1_pa4", pa4_4, 32'd8);
        @(negedge CLK);
        ihit4 = 1'b0;
        #1;
        chk("refill_count", 32'(count4), 32'd4);
        chk("refill_ren", 32'(ren4), 32'd0);
        for (int k = 0; k < 4; k++) begin
            deq4 = 1'b1;
            #1;
            chk("drain_pa4", pa4_4, 32'(8 + 4 * k));
            chk("drain_inst", inst4, imem(32'(4 + 4 * k)));
            $display("txn pop: inst=%h pc_add4=%h", inst4, pa4_4);
            @(negedge CLK);
        end
        deq4 = 1'b0;
        #1;
        chk("empty_count", 32'(count4), 32'd0);
        chk("empty_valid", 32'(valid4), 32'd0);
        chk("empty_inst", inst4, 32'd0);
        chk("empty_pa4", pa4_4, 32'd0);
        chk("empty_addr", addr4, 32'd20);

        // Flush with concurrent ihit: the ihit word must never appear.
        ihit4 = 1'b1;
        load4 = imem(32'd20);
        @(negedge CLK);
        load4 = imem(32'd24);
        @(negedge CLK);
        flush4 = 1'b1;
        redir4 = 32'h100;
        load4 = 32'hDEAD_BEEF;
        #1;
        chk("preflush_count", 32'(count4), 32'd2);
        @(negedge CLK);
        flush4 = 1'b0;
        ihit4 = 1'b0;
        #1;
        chk("flush_count", 32'(count4), 32'd0);
        chk("flush_valid", 32'(valid4), 32'd0);
        chk("flush_addr", addr4, 32'h100);
        chk("flush_inst", inst4, 32'd0);
        $display("txn flush: addr=%h count=%0d", addr4, count4);
        ihit4 = 1'b1;
        load4 = imem(32'h100);
        @(negedge CLK);
        ihit4 = 1'b0;
        #1;
        chk("postflush_count", 32'(count4), 32'd1);
        chk("postflush_inst", inst4, imem(32'h100));
        chk("postflush_pa4", pa4_4, 32'h104);

        // Asynchronous reset mid-operation.
        nRST = 1'b0;
        #1;
        chk("async_rst_count", 32'(count4), 32'd0);
        chk("async_rst_addr", addr4, 32'd0);
        chk("async_rst_valid", 32'(valid4), 32'd0);
        $display("txn async reset: count=%0d addr=%h", count4, addr4);
        @(negedge CLK);
        nRST = 1'b1;

        // HALT fetched at PC 8 stops fetch but still drains.
        ihit4 = 1'b1;
        load4 = imem(32'h0);
        @(negedge CLK);
        load4 = imem(32'h4);
        @(negedge CLK);
        load4 = 32'hFFFF_FFFF;
        #1;
        chk("halt_addr", addr4, 32'd8);
        @(negedge CLK);
        load4 = imem(32'd12);
        #1;
        chk("halt_halted", 32'(halted4), 32'd1);
        chk("halt_ren", 32'(ren4), 32'd0);
        chk("halt_count", 32'(count4), 32'd3);
        chk("halt_addr_stop", addr4, 32'd12);
        @(negedge CLK);
        ihit4 = 1'b0;
        #1;
        chk("halt_nopush", 32'(count4), 32'd3);
        for (int k = 0; k < 3; k++) begin
            deq4 = 1'b1;
            #1;
            chk("halt_drain_pa4", pa4_4, 32'(4 + 4 * k));
            chk("halt_drain_inst", inst4, halt_seq[k]);
            $display("txn pop: inst=%h pc_add4=%h", inst4, pa4_4);
            @(negedge CLK);
        end
        deq4 = 1'b0;
        #1;
        chk("halt_empty_count", 32'(count4), 32'd0);
        chk("halt_sticky", 32'(halted4), 32'd1);
        chk("halt_sticky_ren", 32'(ren4), 32'd0);
        flush4 = 1'b1;
        redir4 = 32'h40;
        @(negedge CLK);
        flush4 = 1'b0;
        #1;
        chk("unhalt_halted", 32'(halted4), 32'd0);
        chk("unhalt_ren", 32'(ren4), 32'd1);
        chk("unhalt_addr", addr4, 32'h40);

        // Empty queue with ihit and deq together.
        ihit4 = 1'b1;
        deq4 = 1'b1;
        load4 = imem(32'h40);
        #1;
        if (BYP) begin
            chk("byp_valid", 32'(valid4), 32'd1);
            chk("byp_inst", inst4, imem(32'h40));
            chk("byp_pa4", pa4_4, 32'h44);
        end else begin
            chk("nobyp_valid", 32'(valid4), 32'd0);
            chk("nobyp_inst", inst4, 32'd0);
        end
        @(negedge CLK);
        ihit4 = 1'b0;
        deq4 = 1'b0;
        #1;
        chk("byp_addr", addr4, 32'h44);
        if (BYP) begin
            chk("byp_count", 32'(count4), 32'd0);
        end else begin
            chk("nobyp_count", 32'(count4), 32'd1);
            chk("nobyp_inst_late", inst4, imem(32'h40));
        end
        $display("txn empty ihit+deq: count=%0d addr=%h", count4, addr4);

        // DEPTH=2 random ihit/deq against a reference queue.
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        mpc = 32'h0;
        for (int c = 0; c < 1000; c++) begin
            logic exp_ren, byp_now, do_push, do_pop;
            logic [31:0] exp_inst, exp_pa4;
            ihit2 = 1'($urandom_range(0, 1));
            deq2 = 1'($urandom_range(0, 1));
            load2 = {8'hA5, mpc[23:0]};
            #1;
            exp_ren = (q_instr.size() < 2);
            byp_now = BYP && (q_instr.size() == 0) && ihit2 && exp_ren && deq2;
            if (byp_now) begin
                exp_inst = load2;
                exp_pa4 = mpc + 32'd4;
            end else if (q_instr.size() != 0) begin
                exp_inst = q_instr[0];
                exp_pa4 = q_pa4[0];
            end else begin
                exp_inst = 32'd0;
                exp_pa4 = 32'd0;
            end
            chk("rnd_ren", 32'(ren2), 32'(exp_ren));
            chk("rnd_addr", addr2, mpc);
            chk("rnd_count", 32'(count2), 32'(q_instr.size()));
            chk("rnd_count_max", 32'(count2 <= 2'd2), 32'd1);
            chk("rnd_valid", 32'(valid2), 32'((q_instr.size() != 0) || byp_now));
            chk("rnd_inst", inst2, exp_inst);
            chk("rnd_pa4", pa4_2, exp_pa4);
            $display("txn rnd %0d: ihit=%0d deq=%0d count=%0d pc_add4=%h", c, ihit2, deq2, count2, pa4_2);
            do_push = ihit2 && exp_ren;
            do_pop = deq2 && (q_instr.size() != 0);
            if (byp_now) begin
                mpc = mpc + 32'd4;
            end else begin
                if (do_pop) begin
                    void'(q_instr.pop_front());
                    void'(q_pa4.pop_front());
                end
                if (do_push) begin
                    q_instr.push_back(load2);
                    q_pa4.push_back(mpc + 32'd4);
                    mpc = mpc + 32'd4;
                end
            end
            @(negedge CLK);
        end
        ihit2 = 1'b0;
        deq2 = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
